// File: rtl/frame_sched_ctrl_pkg.sv
// Shared constants, FSM state encoding and speed-to-period table for the
// frame scheduler.
package frame_sched_pkg;

  localparam int H_TOTAL = 1650;
  localparam int V_TOTAL = 750;
  localparam int V_DISP  = 720;

  localparam int PER_W = 6;

  typedef logic [2:0] speed_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SWAP = 2'd2
  } sched_state_e;

  // Frames between game ticks for each speed index; higher index is faster.
  function automatic logic [PER_W-1:0] speed_period(input speed_sel_t sel);
    logic [PER_W-1:0] p;
    case (sel)
      3'd0:    p = 6'd32;
      3'd1:    p = 6'd24;
      3'd2:    p = 6'd16;
      3'd3:    p = 6'd12;
      3'd4:    p = 6'd8;
      3'd5:    p = 6'd6;
      3'd6:    p = 6'd4;
      default: p = 6'd2;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/frame_sched_ctrl_if.sv
// Video-timing inputs, game-logic handshake and status bundle between the
// video driver / game logic (master) and the frame scheduler (slave).
interface frame_sched_ctrl_if #(
  parameter int FCNT_W = 16
);
  import frame_sched_pkg::*;

  logic              video_vs;
  logic              video_de;
  speed_sel_t        speed_sel;
  logic              pause;
  logic              upd_req;
  logic              upd_ack;
  logic              buf_swap;
  logic              tick;
  logic [FCNT_W-1:0] frame_cnt;
  logic              busy;
  logic              timeout_err;

  modport master (
    output video_vs, video_de, speed_sel, pause, upd_ack,
    input  upd_req, buf_swap, tick, frame_cnt, busy, timeout_err
  );

  modport slave (
    input  video_vs, video_de, speed_sel, pause, upd_ack,
    output upd_req, buf_swap, tick, frame_cnt, busy, timeout_err
  );

endinterface

// File: rtl/frame_sched_ctrl_edge_cnt.sv
// Sync edge detection and active-line counting; emits one frame_done pulse
// when the last active line of a frame ends.
module frame_edge_cnt #(
  parameter int V_DISP = frame_sched_pkg::V_DISP
) (
  input  logic i_pixel_clk,
  input  logic i_sys_rst,
  input  logic i_video_vs,
  input  logic i_video_de,
  output logic o_frame_done
);

  localparam int LINE_W = $clog2(V_DISP + 1);

  logic              r_prev_vs;
  logic              r_prev_de;
  logic              r_vs_fall;
  logic              r_de_fall;
  logic [LINE_W-1:0] r_line_cnt;
  logic              w_at_last;

  // Registered falling-edge detect; vs idles high so its history preloads to 1.
  always_ff @(posedge i_pixel_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_prev_vs <= 1'b1;
      r_prev_de <= 1'b0;
      r_vs_fall <= 1'b0;
      r_de_fall <= 1'b0;
    end else begin
      r_prev_vs <= i_video_vs;
      r_prev_de <= i_video_de;
      r_vs_fall <= r_prev_vs & ~i_video_vs;
      r_de_fall <= r_prev_de & ~i_video_de;
    end
  end

  // Active-line counter: restarts at vsync, saturates at the display height.
  always_ff @(posedge i_pixel_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_line_cnt <= '0;
    end else if (r_vs_fall) begin
      r_line_cnt <= '0;
    end else if (r_de_fall && (r_line_cnt != LINE_W'(V_DISP))) begin
      r_line_cnt <= r_line_cnt + LINE_W'(1);
    end
  end

  assign w_at_last    = (r_line_cnt == LINE_W'(V_DISP - 1));
  assign o_frame_done = r_de_fall & w_at_last & ~r_vs_fall;

endmodule

// File: rtl/frame_sched_ctrl.sv
// Frame scheduler: counts frames, divides them down to game ticks and runs
// the update-request / buffer-swap handshake inside vertical blanking.
//
// state | meaning
// IDLE  | waiting for a game tick
// REQ   | upd_req high, waiting for upd_ack or timeout
// SWAP  | one-cycle buf_swap pulse after acknowledge
module frame_sched_ctrl #(
  parameter int V_DISP      = frame_sched_pkg::V_DISP,
  parameter int TIMEOUT_CYC = 40000,
  parameter int FCNT_W      = 16
) (
  input logic               i_pixel_clk,
  input logic               i_sys_rst,
  frame_sched_ctrl_if.slave bus
);
  import frame_sched_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_SWAP = ST_SWAP;

  logic              w_frame_done;
  logic [PER_W-1:0]  w_period;
  logic [PER_W-1:0]  r_div;
  logic              r_tick;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic [1:0]        r_state;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_upd_req;
  logic              r_buf_swap;
  logic              r_timeout_err;

  frame_edge_cnt #(.V_DISP(V_DISP)) u_edge (
    .i_pixel_clk  (i_pixel_clk),
    .i_sys_rst    (i_sys_rst),
    .i_video_vs   (bus.video_vs),
    .i_video_de   (bus.video_de),
    .o_frame_done (w_frame_done)
  );

  assign w_period = speed_period(bus.speed_sel);

  // Frame counter and tick divider; ">=" lets a speed-up with a large divider fire at once.
  always_ff @(posedge i_pixel_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_frame_cnt <= '0;
      r_div       <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
        if (!bus.pause) begin
          if (r_div >= (w_period - PER_W'(1))) begin
            r_div  <= '0;
            r_tick <= 1'b1;
          end else begin
            r_div <= r_div + PER_W'(1);
          end
        end
      end
    end
  end

  // Handshake FSM; a tick arriving while busy is dropped, ack beats timeout.
  always_ff @(posedge i_pixel_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_upd_req     <= 1'b0;
      r_buf_swap    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_buf_swap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_tick) begin
            r_state   <= S_REQ;
            r_upd_req <= 1'b1;
            r_to_cnt  <= '0;
          end
        end
        S_REQ: begin
          if (bus.upd_ack) begin
            r_state    <= S_SWAP;
            r_upd_req  <= 1'b0;
            r_buf_swap <= 1'b1;
          end else if (r_to_cnt == TO_LAST) begin
            r_state       <= S_IDLE;
            r_upd_req     <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_SWAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_upd_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.upd_req     = r_upd_req;
  assign bus.buf_swap    = r_buf_swap;
  assign bus.tick        = r_tick;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_frame_sched_ctrl.sv
// Bench for frame_sched_ctrl using a shrunken video raster (4 active lines of
// 8 pixels in an 8x12 frame) and a 40-cycle ack timeout.
module tb_frame_sched_ctrl;

  localparam int VD      = 4;
  localparam int TO      = 40;
  localparam int H_ACT   = 8;
  localparam int H_TOT   = 12;
  localparam int V_TOT   = 8;
  localparam int VS_LINE = 5;
  localparam int FR      = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_sched_ctrl_if #(.FCNT_W(16)) bus ();

  frame_sched_ctrl #(.V_DISP(VD), .TIMEOUT_CYC(TO), .FCNT_W(16)) dut (
    .i_pixel_clk (clk),
    .i_sys_rst   (rst),
    .bus         (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int periods [8] = '{32, 24, 16, 12, 8, 6, 4, 2};
  int          m_cyc, m_lines, m_div;
  int          m_frame_edge, m_tick_edge, m_req_edge, m_swap_edge;
  logic [15:0] m_fcnt;
  bit          m_req, m_err, m_last_vs, m_last_de;

  task automatic model_reset();
    m_cyc = 0; m_lines = 0; m_div = 0; m_fcnt = '0;
    m_frame_edge = -10; m_tick_edge = -10; m_req_edge = -10; m_swap_edge = -10;
    m_req = 0; m_err = 0; m_last_vs = 1; m_last_de = 0;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      model_reset();
    end else begin
      m_cyc++;
      if (m_req) begin
        if (bus.upd_ack) begin
          m_req = 0;
          m_swap_edge = m_cyc;
        end else if (m_cyc - m_req_edge == TO) begin
          m_req = 0;
          m_err = 1;
        end
      end else if ((m_swap_edge != m_cyc - 1) && (m_tick_edge == m_cyc - 1)) begin
        m_req = 1;
        m_req_edge = m_cyc;
      end
      if (m_frame_edge == m_cyc) begin
        m_fcnt = m_fcnt + 16'd1;
        if (!bus.pause) begin
          if (m_div >= periods[bus.speed_sel] - 1) begin
            m_div = 0;
            m_tick_edge = m_cyc;
          end else begin
            m_div++;
          end
        end
      end
      if (m_last_vs && !bus.video_vs) m_lines = 0;
      if (m_last_de && !bus.video_de && m_lines < VD) begin
        m_lines++;
        if (m_lines == VD) m_frame_edge = m_cyc + 1;
      end
      m_last_vs = bus.video_vs;
      m_last_de = bus.video_de;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("tick",        bus.tick,        (m_tick_edge == m_cyc));
      chk("upd_req",     bus.upd_req,     m_req);
      chk("buf_swap",    bus.buf_swap,    (m_swap_edge == m_cyc));
      chk("busy",        bus.busy,        (m_req || (m_swap_edge == m_cyc)));
      chk("frame_cnt",   bus.frame_cnt,   m_fcnt);
      chk("timeout_err", bus.timeout_err, m_err);
    end
  end

  // ---------------- monitors ----------------
  int mon_tick, mon_swap, mon_fd, mon_req_run, mon_req_len, mon_req_pulses, mon_first_fc;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.tick) begin
        mon_tick++;
        if (mon_first_fc < 0) mon_first_fc = int'(bus.frame_cnt);
      end
      if (bus.buf_swap) mon_swap++;
      if (dut.u_edge.o_frame_done) mon_fd++;
      if (bus.upd_req) mon_req_run++;
      else if (mon_req_run > 0) begin
        mon_req_len = mon_req_run;
        mon_req_pulses++;
        mon_req_run = 0;
      end
    end
  end

  // Game-logic responder: acknowledges on the 10th cycle of upd_req.
  bit ack_auto;
  int ack_wait;
  initial forever begin
    @(negedge clk);
    if (ack_auto && !rst) begin
      if (bus.upd_req) begin
        ack_wait++;
        if (ack_wait == 10) bus.upd_ack = 1'b1;
      end else begin
        ack_wait = 0;
        bus.upd_ack = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  int pos_line, pos_px;

  task automatic step();
    @(negedge clk);
    bus.video_de = (pos_line < VD) && (pos_px < H_ACT);
    bus.video_vs = (pos_line != VS_LINE);
    pos_px++;
    if (pos_px == H_TOT) begin
      pos_px = 0;
      pos_line = (pos_line + 1) % V_TOT;
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n * FR) step();
  endtask

  task automatic do_reset(input logic [2:0] spd, input logic pz, input bit auto_ack);
    rst = 1'b1;
    bus.video_vs = 1'b1; bus.video_de = 1'b0; bus.upd_ack = 1'b0;
    bus.speed_sel = spd; bus.pause = pz;
    ack_auto = auto_ack; ack_wait = 0;
    pos_line = 0; pos_px = 0;
    mon_tick = 0; mon_swap = 0; mon_fd = 0; mon_req_run = 0;
    mon_req_len = 0; mon_req_pulses = 0; mon_first_fc = -1;
    repeat (3) @(negedge clk);
    chk("rst_upd_req",   bus.upd_req,     0);
    chk("rst_buf_swap",  bus.buf_swap,    0);
    chk("rst_tick",      bus.tick,        0);
    chk("rst_frame_cnt", bus.frame_cnt,   0);
    chk("rst_busy",      bus.busy,        0);
    chk("rst_err",       bus.timeout_err, 0);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    n_chk++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    bit found;

    // Three plain frames at the slowest speed: count only, no tick.
    do_reset(3'd0, 1'b0, 1'b0);
    run_frames(3);
    chk("t1_frame_cnt", bus.frame_cnt, 3);
    chk("t1_frame_done_pulses", mon_fd, 3);
    chk("t1_ticks", mon_tick, 0);

    // Fastest speed, ack after 10 cycles: tick every 2nd frame.
    do_reset(3'd7, 1'b0, 1'b1);
    run_frames(6);
    chk("t2_ticks", mon_tick, 3);
    chk("t2_swaps", mon_swap, 3);
    chk("t2_req_pulses", mon_req_pulses, 3);
    chk("t2_req_len", mon_req_len, 10);
    chk("t2_busy_end", bus.busy, 0);

    // Pause holds the divider; first tick lands on frame 72.
    do_reset(3'd0, 1'b1, 1'b1);
    run_frames(40);
    chk("t3_ticks_paused", mon_tick, 0);
    bus.pause = 1'b0;
    run_frames(32);
    chk("t3_ticks", mon_tick, 1);
    chk("t3_first_tick_frame", mon_first_fc, 72);
    chk("t3_frame_cnt", bus.frame_cnt, 72);

    // No ack: upd_req lasts exactly the timeout, error is sticky, next tick still requests.
    do_reset(3'd7, 1'b0, 1'b0);
    run_frames(4);
    chk("t4_req_pulses", mon_req_pulses, 2);
    chk("t4_req_len", mon_req_len, TO);
    chk("t4_err", bus.timeout_err, 1);
    chk("t4_swaps", mon_swap, 0);

    // Async reset mid-request clears outputs before the next clock edge.
    found = 0;
    for (int i = 0; i < 3 * FR && !found; i++) begin
      step();
      if (bus.upd_req) found = 1;
    end
    chk("t6_req_seen", found, 1);
    chk("t6_pre_err", bus.timeout_err, 1);
    chk("t6_pre_frame_cnt", bus.frame_cnt, 6);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_req", bus.upd_req, 0);
    chk("t6_async_err", bus.timeout_err, 0);
    chk("t6_async_frame_cnt", bus.frame_cnt, 0);
    chk("t6_async_busy", bus.busy, 0);

    // Speed change 0 -> 7 with divider at 10: tick on the very next frame.
    do_reset(3'd0, 1'b0, 1'b1);
    run_frames(10);
    chk("t5_ticks_slow", mon_tick, 0);
    bus.speed_sel = 3'd7;
    run_frames(1);
    chk("t5_ticks_after_change", mon_tick, 1);
    chk("t5_first_tick_frame", mon_first_fc, 11);
    run_frames(2);
    chk("t5_ticks_total", mon_tick, 2);
    chk("t5_swaps", mon_swap, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
